mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single memory/cache port between two requesters: instruction fetch (IF) and the load/store unit (DM).
- Sequences each access: grant, one-cycle MemRead/MemWrite strobe, wait while busy, capture read data, one-cycle ack to the owner.
- Sits between controller/datapath and memory. Busy on the memory side becomes a stall seen by requesters as a missing ack.

Parameters:
- NBITS, 8, address and data width of both requesters and the memory port.
- STARVE_MAX, 3, consecutive DM grants, with IF also pending, after which IF is forced (only with MEM_ARB_FAIR_EN).

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- if_req  in  1  IF read request, level; addr held stable while high
- if_addr  in  NBITS  IF read address
- if_ack  out  1  one-cycle pulse, IF access complete
- if_rdata  out  NBITS  IF read data, valid in the if_ack cycle and held until the next IF ack
- dm_req  in  1  DM request, level
- dm_we  in  1  1 = write, 0 = read
- dm_addr  in  NBITS  DM address
- dm_wdata  in  NBITS  DM write data
- dm_ack  out  1  one-cycle pulse, DM access complete (read or write)
- dm_rdata  out  NBITS  DM read data, valid in the dm_ack cycle and held until the next DM read ack
- mem_addr  out  NBITS  registered address to memory
- mem_wdata  out  NBITS  registered write data
- MemRead  out  1  one-cycle read strobe
- MemWrite  out  1  one-cycle write strobe
- busy  in  1  memory not ready; result valid in the first WAIT cycle with busy=0
- mem_rdata  in  NBITS  memory read data
- owner  out  2  00 none, 01 IF, 10 DM; current transaction owner

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset values: all outputs 0, state IDLE, starve counter 0.
- FSM states: IDLE, ACCESS, WAIT, DONE.
- IDLE: if no request, stay.
  - If a request is present, pick the winner, latch addr/wdata/we into the mem_* registers, set owner, go to ACCESS.
  - Default priority: DM over IF.
- ACCESS, exactly 1 cycle:
  - MemRead=1 if owner is IF or dm_we=0; otherwise MemWrite=1.
  - Never both; strobes are 0 in every other state.
  - Go to WAIT.
- WAIT:
  - busy=1: stay; mem_addr and mem_wdata held; no timeout.
  - busy=0: capture mem_rdata into the owner's rdata register (reads only), go to DONE.
- DONE, 1 cycle: owner's ack=1, then owner cleared to 00, go to IDLE.
- Latency: a request seen in IDLE at cycle n gives ack at n+3 when busy is never high; each busy cycle adds 1.
- Request rules:
  - Req is sampled only in IDLE; changes in other states are ignored. The latched transaction stays unchanged.
  - A requester drops req in the cycle after ack, or a new access is started.
  - A req held high across IDLE means back-to-back accesses.
- Simultaneous if_req and dm_req in IDLE: DM wins; IF waits (if_ack stays 0).
- Write access: dm_ack is pulsed and dm_rdata is left unchanged.
- rdata registers of the non-owner never change.
- Reset mid-transaction (any state): next cycle IDLE, strobes 0, acks 0, owner 00. The transaction is abandoned and not acked.
- Arithmetic: starve counter saturates at STARVE_MAX and never wraps.

Optional Feature:
- Macro: MEM_ARB_FAIR_EN.
- Defined:
  - Starve counter increments on each DM grant made while if_req=1.
  - Counter clears on any IF grant.
  - When counter == STARVE_MAX and both requests are present, IF wins.
- Undefined: counter logic is absent; fixed DM priority.

Test Plan:
- Lone IF read, busy tied 0, if_addr=8'h10, mem_rdata=8'hA5 -> MemRead=1 exactly at cycle+1, mem_addr=8'h10; if_ack at cycle+3; if_rdata=8'hA5; MemWrite never 1.
- DM write, dm_addr=8'h20, dm_wdata=8'h3C, busy high 2 cycles after the strobe -> MemWrite one cycle with mem_wdata=8'h3C; dm_ack at cycle+5; dm_rdata unchanged; mem_addr stable through WAIT.
- Simultaneous if_req and dm_req read (dm_addr=8'h04, if_addr=8'h08) -> DM served first (owner=10, dm_ack); IF access follows with mem_addr=8'h08; if_ack 4 cycles after dm_ack with busy=0.
- Reset asserted during WAIT with busy=1 -> next cycle owner=00, MemRead=MemWrite=0, no ack ever for that transaction; fresh IF request afterwards completes normally.
- Both requesters held high continuously, busy=0 -> without macro, only DM granted; with MEM_ARB_FAIR_EN and STARVE_MAX=3, grant pattern DM,DM,DM,IF repeating.
- if_addr changed from 8'h10 to 8'h55 during WAIT -> mem_addr stays 8'h10, data returned is for 8'h10.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one memory port between instruction fetch and load/store (optional fairness: MEM_ARB_FAIR_EN)
module mem_port_arbiter #(
  parameter int NBITS      = 8,
  parameter int STARVE_MAX = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             if_req,
  input  logic [NBITS-1:0] if_addr,
  output logic             if_ack,
  output logic [NBITS-1:0] if_rdata,
  input  logic             dm_req,
  input  logic             dm_we,
  input  logic [NBITS-1:0] dm_addr,
  input  logic [NBITS-1:0] dm_wdata,
  output logic             dm_ack,
  output logic [NBITS-1:0] dm_rdata,
  output logic [NBITS-1:0] mem_addr,
  output logic [NBITS-1:0] mem_wdata,
  output logic             MemRead,
  output logic             MemWrite,
  input  logic             busy,
  input  logic [NBITS-1:0] mem_rdata,
  output logic [1:0]       owner
);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_e;

  localparam logic [1:0] OWN_NONE = 2'b00;
  localparam logic [1:0] OWN_IF   = 2'b01;
  localparam logic [1:0] OWN_DM   = 2'b10;

  state_e           state_q, state_d;
  logic [1:0]       owner_q, owner_d;
  logic [NBITS-1:0] addr_q, addr_d;
  logic [NBITS-1:0] wdata_q, wdata_d;
  logic             we_q, we_d;
  logic [NBITS-1:0] if_rdata_q, if_rdata_d;
  logic [NBITS-1:0] dm_rdata_q, dm_rdata_d;
  logic             grant_if;

`ifdef MEM_ARB_FAIR_EN
  localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

  logic [SW-1:0] starve_q, starve_d;

  // IF wins a contested grant once DM has been chosen STARVE_MAX times in a row over it
  always_comb begin
    grant_if = if_req && (!dm_req || (starve_q == SW'(STARVE_MAX)));
  end

  // count contested DM grants, saturating; any IF grant clears the count
  always_comb begin
    starve_d = starve_q;
    if (state_q == IDLE && (if_req || dm_req)) begin
      if (grant_if) begin
        starve_d = '0;
      end else if (if_req && (starve_q != SW'(STARVE_MAX))) begin
        starve_d = starve_q + SW'(1);
      end
    end
  end

  // starve counter register
  always_ff @(posedge clock) begin
    if (reset) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end
`else
  // fixed priority: DM always beats IF
  always_comb begin
    grant_if = if_req && !dm_req;
  end
`endif

  // next-state, transaction latching and strobe/ack decode
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    we_d       = we_q;
    if_rdata_d = if_rdata_q;
    dm_rdata_d = dm_rdata_q;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    if_ack     = 1'b0;
    dm_ack     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (if_req || dm_req) begin
          state_d = ACCESS;
          if (grant_if) begin
            owner_d = OWN_IF;
            addr_d  = if_addr;
            we_d    = 1'b0;
          end else begin
            owner_d = OWN_DM;
            addr_d  = dm_addr;
            wdata_d = dm_wdata;
            we_d    = dm_we;
          end
        end
      end
      ACCESS: begin
        MemRead  = (owner_q == OWN_IF) || !we_q;
        MemWrite = (owner_q == OWN_DM) && we_q;
        state_d  = WAIT;
      end
      WAIT: begin
        if (!busy) begin
          state_d = DONE;
          if (owner_q == OWN_IF) begin
            if_rdata_d = mem_rdata;
          end else if (!we_q) begin
            dm_rdata_d = mem_rdata;
          end
        end
      end
      DONE: begin
        if_ack  = (owner_q == OWN_IF);
        dm_ack  = (owner_q == OWN_DM);
        owner_d = OWN_NONE;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // state and datapath registers; reset abandons any transaction in flight
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      owner_q    <= OWN_NONE;
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
      if_rdata_q <= if_rdata_d;
      dm_rdata_q <= dm_rdata_d;
    end
  end

  assign owner     = owner_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - randomized self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;
  localparam int NBITS      = 8;
  localparam int STARVE_MAX = 3;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             if_req = 1'b0;
  logic [NBITS-1:0] if_addr = '0;
  logic             if_ack;
  logic [NBITS-1:0] if_rdata;
  logic             dm_req = 1'b0;
  logic             dm_we = 1'b0;
  logic [NBITS-1:0] dm_addr = '0;
  logic [NBITS-1:0] dm_wdata = '0;
  logic             dm_ack;
  logic [NBITS-1:0] dm_rdata;
  logic [NBITS-1:0] mem_addr;
  logic [NBITS-1:0] mem_wdata;
  logic             MemRead;
  logic             MemWrite;
  logic             busy = 1'b0;
  logic [NBITS-1:0] mem_rdata;
  logic [1:0]       owner;

  mem_port_arbiter #(.NBITS(NBITS), .STARVE_MAX(STARVE_MAX)) dut (
    .clock(clock), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_ack(dm_ack), .dm_rdata(dm_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .MemRead(MemRead), .MemWrite(MemWrite),
    .busy(busy), .mem_rdata(mem_rdata), .owner(owner)
  );

  always #5 clock = ~clock;

  // memory environment: array written on MemWrite, garbage on the data bus while busy
  logic [7:0] mem_arr [256];
  logic [7:0] junk;
  always @(posedge clock) begin
    junk <= 8'($urandom);
    if (reset) begin
      for (int i = 0; i < 256; i++) mem_arr[i] <= 8'(i * 37 + 11);
    end else if (MemWrite) begin
      mem_arr[mem_addr] <= mem_wdata;
    end
  end
  assign mem_rdata = busy ? junk : mem_arr[mem_addr];

  // reference model state
  logic [7:0] ref_arr [256];
  logic [7:0] exp_if_rd, exp_dm_rd;
  int         starve_m;
  int         n_vec, n_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic init_ref();
    for (int i = 0; i < 256; i++) ref_arr[i] = 8'(i * 37 + 11);
    exp_if_rd = '0;
    exp_dm_rd = '0;
    starve_m  = 0;
  endtask

  // winner among currently presented requests: 1 = IF, 2 = DM
  function automatic int pick();
    if (dm_req && if_req) begin
`ifdef MEM_ARB_FAIR_EN
      if (starve_m == STARVE_MAX) return 1;
`endif
      return 2;
    end
    if (dm_req) return 2;
    return 1;
  endfunction

  task automatic idle_checks(input string tag);
    check({tag, "_owner"}, 32'(owner), 32'd0);
    check({tag, "_acks"}, 32'({if_ack, dm_ack}), 32'd0);
    check({tag, "_strb"}, 32'({MemRead, MemWrite}), 32'd0);
  endtask

  // Called at the negedge of an IDLE cycle with requests presented; returns at the next IDLE negedge.
  task automatic run_access(input bit keep_req, input int nb_in, output int who);
    logic [7:0] a, wd;
    logic       w;
    int         nb;
    who = pick();
    a   = (who == 2) ? dm_addr : if_addr;
    w   = (who == 2) ? dm_we : 1'b0;
    wd  = dm_wdata;
    if (who == 1) starve_m = 0;
    else if (if_req) starve_m = (starve_m < STARVE_MAX) ? starve_m + 1 : STARVE_MAX;
    nb   = (nb_in < 0) ? int'($urandom_range(0, 3)) : nb_in;
    busy = 1'($urandom_range(0, 1));
    @(negedge clock);
    check("acc_owner", 32'(owner), 32'(who));
    check("acc_rd", 32'(MemRead), 32'(!w));
    check("acc_wr", 32'(MemWrite), 32'(w));
    check("acc_addr", 32'(mem_addr), 32'(a));
    if (w) check("acc_wdata", 32'(mem_wdata), 32'(wd));
    check("acc_acks", 32'({if_ack, dm_ack}), 32'd0);
    if (who == 1) begin
      if_addr = 8'($urandom);
    end else begin
      dm_addr  = 8'($urandom);
      dm_wdata = 8'($urandom);
      dm_we    = 1'($urandom);
    end
    busy = 1'($urandom_range(0, 1));
    for (int i = 0; i <= nb; i++) begin
      @(negedge clock);
      check("wait_owner", 32'(owner), 32'(who));
      check("wait_strb", 32'({MemRead, MemWrite}), 32'd0);
      check("wait_acks", 32'({if_ack, dm_ack}), 32'd0);
      check("wait_addr", 32'(mem_addr), 32'(a));
      busy = (i < nb);
    end
    @(negedge clock);
    if (who == 1) exp_if_rd = ref_arr[a];
    else if (!w) exp_dm_rd = ref_arr[a];
    else ref_arr[a] = wd;
    check("done_if_ack", 32'(if_ack), 32'(who == 1));
    check("done_dm_ack", 32'(dm_ack), 32'(who == 2));
    check("done_owner", 32'(owner), 32'(who));
    check("done_strb", 32'({MemRead, MemWrite}), 32'd0);
    check("if_rdata", 32'(if_rdata), 32'(exp_if_rd));
    check("dm_rdata", 32'(dm_rdata), 32'(exp_dm_rd));
    busy = 1'($urandom_range(0, 1));
    if (!keep_req) begin
      if (who == 1) if_req = 1'b0;
      else dm_req = 1'b0;
    end
    @(negedge clock);
    idle_checks("idle");
  endtask

  task automatic drain();
    int who;
    while (if_req || dm_req) run_access(1'b0, -1, who);
  endtask

  initial begin
    int who;
    int s;
    n_vec = 0;
    n_err = 0;
    init_ref();
    repeat (2) @(negedge clock);
    idle_checks("rst");
    check("rst_addr", 32'(mem_addr), 32'd0);
    check("rst_wdata", 32'(mem_wdata), 32'd0);
    check("rst_rdata", 32'({if_rdata, dm_rdata}), 32'd0);
    reset = 1'b0;

    // DM write 0x10 = A5, then lone IF read of it
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 8'h10; dm_wdata = 8'hA5;
    run_access(1'b0, 0, who);
    if_req = 1'b1; if_addr = 8'h10;
    run_access(1'b0, 0, who);
    check("if_read_a5", 32'(if_rdata), 32'h0A5);

    // DM write with two busy cycles
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 8'h20; dm_wdata = 8'h3C;
    run_access(1'b0, 2, who);

    // simultaneous reads: DM first, IF follows
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 8'h04;
    if_req = 1'b1; if_addr = 8'h08;
    run_access(1'b0, 0, who);
    check("sim_first", 32'(who), 32'd2);
    run_access(1'b0, 0, who);
    check("sim_second", 32'(who), 32'd1);

    // reset during a busy WAIT abandons the transaction
    if_req = 1'b1; if_addr = 8'h33;
    @(negedge clock);
    busy = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    idle_checks("midrst");
    check("midrst_rdata", 32'(if_rdata), 32'd0);
    reset = 1'b0; if_req = 1'b0; busy = 1'b0;
    init_ref();
    repeat (3) begin
      @(negedge clock);
      idle_checks("postrst");
    end
    if_req = 1'b1; if_addr = 8'h33;
    run_access(1'b0, 1, who);

    // both requesters held continuously
    if_req = 1'b1; if_addr = 8'h40;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 8'h41;
    for (int k = 0; k < 8; k++) begin
      run_access(1'b1, 0, who);
`ifdef MEM_ARB_FAIR_EN
      check("fair_grant", 32'(who), (k % 4 == 3) ? 32'd1 : 32'd2);
`else
      check("fixed_grant", 32'(who), 32'd2);
`endif
    end
    dm_req = 1'b0;
    drain();

    // randomized traffic
    for (int n = 0; n < 40; n++) begin
      s        = int'($urandom_range(0, 2));
      if_addr  = 8'($urandom);
      dm_addr  = 8'($urandom);
      dm_wdata = 8'($urandom);
      dm_we    = 1'($urandom);
      if_req   = (s != 1);
      dm_req   = (s != 0);
      drain();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
